// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: frame geometry helpers and pixel layout.
// Pixels are RGB565 packed as {r, b, g} to match the video output path.
package fb_pkg;

  localparam int PIX_W_DEF = 16;

  localparam int R_OFS = 11;
  localparam int R_W   = 5;
  localparam int B_OFS = 6;
  localparam int B_W   = 5;
  localparam int G_OFS = 0;
  localparam int G_W   = 6;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [B_W-1:0] b;
    logic [G_W-1:0] g;
  } rgb565_t;

  function automatic int unsigned frame_words(
    input int unsigned h,
    input int unsigned v
  );
    return h * v;
  endfunction

  function automatic int unsigned buf_base(
    input logic        sel,
    input int unsigned fw
  );
    return sel ? fw : 0;
  endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Bundle of display, writer, swap-control and RAM-port signals.
// The slave side is the arbiter; the master side is its environment.
interface fb_scan_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 16
);

  logic              sfetch;
  logic              snextframe;
  logic [PIX_W-1:0]  sdata;
  logic              svalid;

  logic              wr_req;
  logic [ADDR_W-2:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ack;
  logic              wr_err;

  logic              swap_req;
  logic              swap_ack;
  logic              front_sel;
  logic              overrun;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  sfetch, snextframe,
    input  wr_req, wr_addr, wr_data,
    input  swap_req, mem_rdata,
    output sdata, svalid,
    output wr_ack, wr_err,
    output swap_ack, front_sel, overrun,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output sfetch, snextframe,
    output wr_req, wr_addr, wr_data,
    output swap_req, mem_rdata,
    input  sdata, svalid,
    input  wr_ack, wr_err,
    input  swap_ack, front_sel, overrun,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_rd_pipe.sv
// Display read return path: valid-bit delay line matching RAM latency,
// followed by the registered sdata/svalid stage.
module fb_rd_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int PIX_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_fetch,
  input  logic [PIX_W-1:0] i_rdata,
  output logic [PIX_W-1:0] o_sdata,
  output logic             o_svalid
);

  logic [RD_LATENCY-1:0] r_vld;
  logic [PIX_W-1:0]      r_sdata;
  logic                  r_svalid;
  logic                  w_ret;

  assign w_ret = r_vld[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_fetch;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // sdata is forced to zero whenever no read is returning
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sdata  <= '0;
      r_svalid <= 1'b0;
    end else begin
      r_sdata  <= w_ret ? i_rdata : '0;
      r_svalid <= w_ret;
    end
  end

  assign o_sdata  = r_sdata;
  assign o_svalid = r_svalid;

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: display reads win, writes fill gaps,
// and front/back buffer swaps are deferred to frame boundaries.
module fb_scan_arbiter
  import fb_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 20
) (
  input logic               clk,
  input logic               reset_n,
  fb_scan_arbiter_if.slave  bus
);

  localparam int unsigned FW = frame_words(H_ACTIVE, V_ACTIVE);
  localparam int SW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] FW_A = ADDR_W'(FW);
  localparam logic [SW-1:0] FW_LAST = SW'(FW - 1);

  logic [SW-1:0]     r_scan;
  logic              r_front;
  logic              r_pend;
  logic              r_swap_ack;
  logic              r_overrun;

  logic              w_fetch;
  logic              w_nf;
  logic              w_do_swap;
  logic              w_front;
  logic [SW-1:0]     w_scan;
  logic              w_wr;
  logic              w_oor;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [PIX_W-1:0]  w_sdata;
  logic              w_svalid;

  assign w_fetch   = reset_n & bus.sfetch;
  assign w_nf      = reset_n & bus.snextframe;
  assign w_do_swap = w_nf & (r_pend | bus.swap_req);

  // a fetch coincident with the boundary already sees the new front
  assign w_front = w_do_swap ? ~r_front : r_front;
  assign w_scan  = w_nf ? '0 : r_scan;

  assign w_wr    = reset_n & bus.wr_req & ~bus.sfetch;
  assign w_oor   = {1'b0, bus.wr_addr} >= FW_A;
  assign w_wr_ok = w_wr & ~w_oor;

  assign w_rd_addr = ADDR_W'(buf_base(w_front, FW))
                   + {1'b0, w_scan};
  assign w_wr_addr = ADDR_W'(buf_base(~r_front, FW))
                   + {1'b0, bus.wr_addr};

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      w_fetch: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = w_rd_addr;
      end
      w_wr_ok: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_wr_addr;
        bus.mem_wdata = bus.wr_data;
      end
      default: ;
    endcase
  end

  assign bus.wr_ack = w_wr;
  assign bus.wr_err = w_wr & w_oor;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scan    <= '0;
      r_overrun <= 1'b0;
    end else if (w_fetch) begin
      if (w_scan == FW_LAST) begin
        r_scan    <= '0;
        r_overrun <= 1'b1;
      end else begin
        r_scan <= w_scan + SW'(1);
      end
    end else if (w_nf) begin
      r_scan <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_front    <= 1'b0;
      r_pend     <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= w_do_swap;
      if (w_do_swap) begin
        r_front <= ~r_front;
        r_pend  <= 1'b0;
      end else if (bus.swap_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  fb_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .PIX_W      (PIX_W)
  ) u_rd_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_fetch  (w_fetch),
    .i_rdata  (bus.mem_rdata),
    .o_sdata  (w_sdata),
    .o_svalid (w_svalid)
  );

  assign bus.sdata     = w_sdata;
  assign bus.svalid    = w_svalid;
  assign bus.swap_ack  = r_swap_ack;
  assign bus.front_sel = r_front;
  assign bus.overrun   = r_overrun;

endmodule
